// File: rtl/mem_port_arbiter_if.sv
// Port-A bundle between the two requesters, the arbiter and the vendor SRAM.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              REQ0;
    logic              WE0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] WDATA0;
    logic              GNT0;
    logic              RVALID0;

    logic              REQ1;
    logic              WE1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA1;
    logic              GNT1;
    logic              RVALID1;

    logic [DATA_W-1:0] RDATA;
    logic              BUSY;

    logic              MEM_CEN;
    logic              MEM_WEN;
    logic [ADDR_W-1:0] MEM_A;
    logic [DATA_W-1:0] MEM_D;
    logic              MEM_OEN;
    logic [DATA_W-1:0] MEM_Q;

    modport slave (
        input  REQ0, WE0, ADDR0, WDATA0,
        input  REQ1, WE1, ADDR1, WDATA1,
        input  MEM_Q,
        output GNT0, RVALID0, GNT1, RVALID1,
        output RDATA, BUSY,
        output MEM_CEN, MEM_WEN, MEM_A, MEM_D, MEM_OEN
    );

    modport master (
        output REQ0, WE0, ADDR0, WDATA0,
        output REQ1, WE1, ADDR1, WDATA1,
        output MEM_Q,
        input  GNT0, RVALID0, GNT1, RVALID1,
        input  RDATA, BUSY,
        input  MEM_CEN, MEM_WEN, MEM_A, MEM_D, MEM_OEN
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for SRAM port A shared by two requesters, with registered command issue.
// Define MEMARB_INIT_EN to add a post-reset sweep writing INIT_VALUE to every word before granting.
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 4096,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                CLK,
    input  logic                RSTN,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic              cen;
        logic              wen;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } mem_cmd_t;

    mem_cmd_t cmd_q, cmd_d;
    logic     gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic     rv0_q, rv0_d, rv1_q, rv1_d;
    logic     rr_q, rr_d;
    logic     elig0, elig1, win0, win1, arb_en;

`ifdef MEMARB_INIT_EN
    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_ARB = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
`else
    logic unused_init_cfg;
    assign unused_init_cfg = ^{INIT_VALUE, 32'(DEPTH), 32'(CNT_W)};
`endif

    // State and output registers; rr_q=1 means R1 is preferred on a tie.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cmd_q   <= '{cen: 1'b1, wen: 1'b1, a: '0, d: '0};
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rr_q    <= 1'b0;
`ifdef MEMARB_INIT_EN
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`endif
        end else begin
            cmd_q   <= cmd_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rr_q    <= rr_d;
`ifdef MEMARB_INIT_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`endif
        end
    end

    // Next-state: init sweep, eligibility, round-robin pick and command staging.
    always_comb begin
        cmd_d     = cmd_q;
        cmd_d.cen = 1'b1;
        cmd_d.wen = 1'b1;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rr_d      = rr_q;
        // a read presented during a grant cycle is sampled by the SRAM at its end
        rv0_d     = gnt0_q & ~cmd_q.cen & cmd_q.wen;
        rv1_d     = gnt1_q & ~cmd_q.cen & cmd_q.wen;
        elig0     = bus.REQ0 & ~gnt0_q;
        elig1     = bus.REQ1 & ~gnt1_q;
`ifdef MEMARB_INIT_EN
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        arb_en    = 1'b0;
        case (state_q)
            ST_INIT: begin
                // counter reaching DEPTH marks the idle cycle after the last sweep write
                if (cnt_q == CNT_W'(DEPTH)) begin
                    busy_d  = 1'b0;
                    state_d = ST_ARB;
                end else begin
                    cmd_d.cen = 1'b0;
                    cmd_d.wen = 1'b0;
                    cmd_d.a   = cnt_q[ADDR_W-1:0];
                    cmd_d.d   = INIT_VALUE;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_ARB:  arb_en = 1'b1;
            default: state_d = ST_INIT;
        endcase
`else
        arb_en    = 1'b1;
`endif
        win0 = arb_en & elig0 & (~elig1 | ~rr_q);
        win1 = arb_en & elig1 & (~elig0 | rr_q);
        if (win0) begin
            cmd_d  = '{cen: 1'b0, wen: ~bus.WE0, a: bus.ADDR0, d: bus.WDATA0};
            gnt0_d = 1'b1;
            rr_d   = 1'b1;
        end else if (win1) begin
            cmd_d  = '{cen: 1'b0, wen: ~bus.WE1, a: bus.ADDR1, d: bus.WDATA1};
            gnt1_d = 1'b1;
            rr_d   = 1'b0;
        end
    end

    assign bus.GNT0    = gnt0_q;
    assign bus.GNT1    = gnt1_q;
    assign bus.RVALID0 = rv0_q;
    assign bus.RVALID1 = rv1_q;
    assign bus.RDATA   = bus.MEM_Q;
    assign bus.MEM_CEN = cmd_q.cen;
    assign bus.MEM_WEN = cmd_q.wen;
    assign bus.MEM_A   = cmd_q.a;
    assign bus.MEM_D   = cmd_q.d;
    assign bus.MEM_OEN = 1'b0;
`ifdef MEMARB_INIT_EN
    assign bus.BUSY    = busy_q;
`else
    assign bus.BUSY    = 1'b0;
`endif

    // Only one command can be in flight per cycle, so grants and returns are exclusive.
    a_one_gnt: assert property (@(posedge CLK) disable iff (!RSTN) !(gnt0_q && gnt1_q));
    a_one_rv:  assert property (@(posedge CLK) disable iff (!RSTN) !(rv0_q && rv1_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for arbitration/read return plus init and reset sequences.
module tb_mem_port_arbiter;

    logic CLK;
    logic RSTN;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.INIT_VALUE(32'hA5A5A5A5)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

`ifdef MEMARB_INIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM port A model: write or read at the sampling edge, Q holds between reads
    logic [31:0] mem [0:4095];
    always @(posedge CLK) begin
        if (!bus.MEM_CEN) begin
            if (!bus.MEM_WEN) mem[bus.MEM_A] <= bus.MEM_D;
            else              bus.MEM_Q      <= mem[bus.MEM_A];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int wr_idx = 0;
    int wr_bad = 0;
    int busy_gnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Sweep monitor: every busy write must be INIT_VALUE to the next address in order
    always @(negedge CLK) begin
        if (RSTN && bus.BUSY) begin
            if (bus.GNT0 || bus.GNT1 || bus.RVALID0 || bus.RVALID1) busy_gnt++;
            if (!bus.MEM_CEN) begin
                if (bus.MEM_WEN !== 1'b0 || bus.MEM_A !== wr_idx[11:0] || bus.MEM_D !== 32'hA5A5A5A5)
                    wr_bad++;
                wr_idx++;
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTN) begin
            chk1("rvalid_overlap", bus.RVALID0 & bus.RVALID1, 1'b0);
            chk1("gnt_overlap", bus.GNT0 & bus.GNT1, 1'b0);
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [11:0] a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [11:0] a1;
        logic [31:0] d1;
        logic        g0, g1, v0, v1;
        logic [31:0] rd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [31:0] r0, w0, a0, d0, r1, w1, a1, d1,
                                input logic [31:0] g0, g1, v0, v1, rd);
        vec_t v;
        v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[11:0]; v.d0 = d0;
        v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[11:0]; v.d1 = d1;
        v.g0 = g0[0]; v.g1 = g1[0]; v.v0 = v0[0]; v.v1 = v1[0]; v.rd = rd;
        vq.push_back(v);
    endfunction

    task automatic idle_inputs();
        bus.REQ0 = 1'b0; bus.WE0 = 1'b0; bus.ADDR0 = '0; bus.WDATA0 = '0;
        bus.REQ1 = 1'b0; bus.WE1 = 1'b0; bus.ADDR1 = '0; bus.WDATA1 = '0;
    endtask

    // Issue one read from a requester, wait (bounded) for its grant, then check the return
    task automatic do_read(input int port, input logic [11:0] addr, input logic [31:0] exp,
                           input string name);
        logic got;
        got = 1'b0;
        if (port == 0) begin bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = addr; end
        else           begin bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.ADDR1 = addr; end
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if ((port == 0) ? bus.GNT0 : bus.GNT1) begin
                got = 1'b1;
                break;
            end
        end
        chk1({name, "_gnt"}, got, 1'b1);
        idle_inputs();
        @(negedge CLK);
        chk1({name, "_rvalid"}, (port == 0) ? bus.RVALID0 : bus.RVALID1, 1'b1);
        chk32({name, "_rdata"}, bus.RDATA, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int   busy_cnt;

        // cycle-by-cycle vectors: inputs driven in that cycle, outputs expected in that cycle
        add(1,1,'h123,'hDEADBEEF, 0,0,0,0,               0,0,0,0,0);
        add(1,0,'h123,0,          0,0,0,0,               1,0,0,0,0);
        add(1,0,'h123,0,          0,0,0,0,               0,0,0,0,0);
        add(0,0,0,0,              0,0,0,0,               1,0,0,0,0);
        add(1,1,1,'h11111111,     1,1,2,'h22222222,      0,0,1,0,'hDEADBEEF);
        add(1,1,1,'h11111111,     1,0,2,0,               0,1,0,0,0);
        add(1,0,1,0,              1,0,2,0,               1,0,0,0,0);
        add(1,0,1,0,              1,0,2,0,               0,1,0,0,0);
        add(1,0,1,0,              1,0,2,0,               1,0,0,1,'h22222222);
        add(1,0,1,0,              1,0,2,0,               0,1,1,0,'h11111111);
        add(0,0,0,0,              1,0,2,0,               1,0,0,1,'h22222222);
        add(0,0,0,0,              0,0,0,0,               0,1,1,0,'h11111111);
        add(0,0,0,0,              0,0,0,0,               0,0,0,1,'h22222222);
        add(1,0,1,0,              0,0,0,0,               0,0,0,0,0);
        add(1,0,1,0,              0,0,0,0,               1,0,0,0,0);
        add(1,0,1,0,              0,0,0,0,               0,0,1,0,'h11111111);
        add(0,0,0,0,              0,0,0,0,               1,0,0,0,0);
        add(0,0,0,0,              0,0,0,0,               0,0,1,0,'h11111111);
        add(1,0,7,0,              1,1,7,'h42,            0,0,0,0,0);
        add(1,0,7,0,              0,0,0,0,               0,1,0,0,0);
        add(0,0,0,0,              0,0,0,0,               1,0,0,0,0);
        add(0,0,0,0,              0,0,0,0,               0,0,1,0,'h42);
        add(0,0,0,0,              0,0,0,0,               0,0,0,0,0);

        RSTN = 1'b0;
        idle_inputs();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk1 ("rst_mem_cen", bus.MEM_CEN, 1'b1);
        chk1 ("rst_mem_wen", bus.MEM_WEN, 1'b1);
        chk32("rst_mem_a",   32'(bus.MEM_A), 0);
        chk32("rst_mem_d",   bus.MEM_D, 0);
        chk1 ("rst_gnt0",    bus.GNT0, 1'b0);
        chk1 ("rst_gnt1",    bus.GNT1, 1'b0);
        chk1 ("rst_rvalid0", bus.RVALID0, 1'b0);
        chk1 ("rst_rvalid1", bus.RVALID1, 1'b0);
        chk1 ("rst_busy",    bus.BUSY, BUSY_RST);
        chk1 ("rst_mem_oen", bus.MEM_OEN, 1'b0);
        RSTN = 1'b1;

`ifdef MEMARB_INIT_EN
        // R0 request held across the whole sweep must stay pending
        bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 12'h000;
        @(posedge CLK);
        busy_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) break;
            busy_cnt++;
        end
        chk32("init_busy_cycles", busy_cnt, 4096);
        chk32("init_write_count", wr_idx, 4096);
        chk32("init_write_bad",   wr_bad, 0);
        chk32("init_busy_grants", busy_gnt, 0);
        @(negedge CLK);
        chk1("init_held_gnt0", bus.GNT0, 1'b1);
        idle_inputs();
        @(negedge CLK);
        chk1 ("init_rd0_rvalid", bus.RVALID0, 1'b1);
        chk32("init_rd0_rdata",  bus.RDATA, 32'hA5A5A5A5);
        do_read(1, 12'hFFF, 32'hA5A5A5A5, "init_rd4095");
`else
        @(negedge CLK);
        chk1("post_rst_busy", bus.BUSY, 1'b0);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            chk1($sformatf("v%0d_gnt0", i),    bus.GNT0,    vq[i].g0);
            chk1($sformatf("v%0d_gnt1", i),    bus.GNT1,    vq[i].g1);
            chk1($sformatf("v%0d_rvalid0", i), bus.RVALID0, vq[i].v0);
            chk1($sformatf("v%0d_rvalid1", i), bus.RVALID1, vq[i].v1);
            chk1($sformatf("v%0d_mem_cen", i), bus.MEM_CEN, ~(vq[i].g0 | vq[i].g1));
            if (vq[i].v0 || vq[i].v1)
                chk32($sformatf("v%0d_rdata", i), bus.RDATA, vq[i].rd);
            bus.REQ0 = vq[i].r0; bus.WE0 = vq[i].w0; bus.ADDR0 = vq[i].a0; bus.WDATA0 = vq[i].d0;
            bus.REQ1 = vq[i].r1; bus.WE1 = vq[i].w1; bus.ADDR1 = vq[i].a1; bus.WDATA1 = vq[i].d1;
        end

        do_read(1, 12'h007, 32'h00000042, "r1_rd7");

        // Reset between a read grant and its return: the return must be dropped
        got = 1'b0;
        bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 12'h007;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (bus.GNT0) begin
                got = 1'b1;
                break;
            end
        end
        chk1("midrst_gnt0", got, 1'b1);
        idle_inputs();
        RSTN = 1'b0;
        #1;
        chk1 ("midrst_mem_cen", bus.MEM_CEN, 1'b1);
        chk1 ("midrst_gnt0",    bus.GNT0, 1'b0);
        chk32("midrst_mem_a",   32'(bus.MEM_A), 0);
        chk1 ("midrst_busy",    bus.BUSY, BUSY_RST);
        @(negedge CLK);
        chk1("midrst_rvalid0_in_rst", bus.RVALID0, 1'b0);
        RSTN = 1'b1;
        @(negedge CLK);
        chk1("midrst_rvalid0_after", bus.RVALID0, 1'b0);
        chk1("midrst_rvalid1_after", bus.RVALID1, 1'b0);
`ifdef MEMARB_INIT_EN
        chk1 ("midrst_sweep_busy", bus.BUSY, 1'b1);
        chk1 ("midrst_sweep_cen",  bus.MEM_CEN, 1'b0);
        chk32("midrst_sweep_a0",   32'(bus.MEM_A), 0);
`else
        chk1 ("midrst_idle_cen",   bus.MEM_CEN, 1'b1);
        chk1 ("midrst_idle_busy",  bus.BUSY, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencer and arbiter for port A of a 4096x32 two-port vendor SRAM.
- Shares port A between two requesters (R0, R1) with round-robin arbitration and a one-grant-per-cycle command issue.
- Returns read data with a valid strobe.
- Optionally clears the whole array after reset before granting any request.
- Port B of the SRAM is untouched and stays dedicated to its own master.

Parameters:
- ADDR_W, 12, address width of the SRAM port.
- DATA_W, 32, data width of the SRAM port.
- DEPTH, 4096, number of words; init sweeps addresses 0..DEPTH-1.
- INIT_VALUE, 32'h0, word written to every location during init.

Ports:
- CLK  in  1  single clock; all logic on posedge; same clock as SRAM CLKA.
- RSTN  in  1  asynchronous active-low reset.
- REQ0  in  1  requester 0 command request; held with command fields until GNT0.
- WE0  in  1  requester 0: 1 = write, 0 = read.
- ADDR0  in  ADDR_W  requester 0 address.
- WDATA0  in  DATA_W  requester 0 write data.
- GNT0  out  1  one-cycle grant pulse to requester 0.
- RVALID0  out  1  read data valid for requester 0.
- REQ1, WE1, ADDR1, WDATA1, GNT1, RVALID1  same as above, for requester 1.
- RDATA  out  DATA_W  read data; qualified by RVALID0 or RVALID1.
- BUSY  out  1  init sweep in progress; no grants issued.
- MEM_CEN  out  1  to SRAM CENA, active-low.
- MEM_WEN  out  1  to SRAM WENA; 0 = write, 1 = read.
- MEM_A  out  ADDR_W  to SRAM AA.
- MEM_D  out  DATA_W  to SRAM DA.
- MEM_OEN  out  1  to SRAM OENA; tied 0.
- MEM_Q  in  DATA_W  from SRAM QA.

Behaviour:
- Interface: one clock (CLK); reset RSTN is asynchronous, active-low.
- Reset values:
  - MEM_CEN=1, MEM_WEN=1, MEM_A=0, MEM_D=0.
  - GNT0=GNT1=0, RVALID0=RVALID1=0.
  - Round-robin pointer = R0 preferred.
  - BUSY=1 with MEMARB_INIT_EN, else 0.
- SRAM model: samples CEN/WEN/A/D at posedge. On a read, MEM_Q updates at that same edge and holds until the next read.
- States: INIT (only with macro), ARB.
- Eligibility: REQi is eligible in cycle c only if GNTi=0 in cycle c. This stops a held request from being granted twice.
- Arbitration in ARB, cycle c:
  - Only one requester eligible: it wins.
  - Both eligible: the one not granted last wins. Pointer toggles after every grant.
  - None eligible: idle.
- Command issue: at the end of cycle c, the winner's command is registered onto MEM_* (MEM_CEN=0, MEM_WEN=~WEi, MEM_A=ADDRi, MEM_D=WDATAi), and GNTi=1 for cycle c+1.
  - With no winner: MEM_CEN=1, MEM_WEN=1; A and D hold their previous values.
- Requester obligation: hold REQi/WEi/ADDRi/WDATAi stable until it sees GNTi. It may drop or change them in the GNT cycle.
- Read return: the SRAM samples the command at the end of c+1, and RVALIDi=1 for cycle c+2 only. RDATA = MEM_Q (combinational pass-through) in that cycle.
  - Writes never raise RVALID.
- Throughput:
  - Alternating R0/R1: one command per cycle, back-to-back.
  - Single requester: one command every 2 cycles.
  - RVALID0 and RVALID1 are never high in the same cycle.
- Ordering: write then read to the same address, even from different requesters, returns the new data. Commands are serialized and the SRAM write completes at its edge.
- Init sweep (INIT state):
  - Counter runs 0..DEPTH-1, one write per cycle: MEM_CEN=0, MEM_WEN=0, MEM_D=INIT_VALUE.
  - No GNT or RVALID during init; requests are held pending.
  - After the write of address DEPTH-1 is issued, BUSY falls on the next cycle and the state moves to ARB. Arbitration starts in the first cycle with BUSY=0.
  - Init takes DEPTH cycles of BUSY=1, counted from the first clock after RSTN deasserts.
- Reset mid-operation: all outputs return to reset values immediately. Any in-flight read is dropped (no RVALID). Init restarts from address 0.
- Address arithmetic: the counter is ADDR_W+1 bits wide to detect terminal DEPTH-1 without wrap. Requester addresses pass unchanged with no range check.

Optional Feature:
- Macro: MEMARB_INIT_EN.
- Defined: INIT state present; the post-reset clear sweep runs exactly as described under Behaviour.
- Undefined: no INIT state or counter; BUSY is tied 0; ARB is entered directly out of reset; SRAM contents are undefined until written.

Test Plan:
- Init sweep (macro on, DEPTH=4096, INIT_VALUE=32'hA5A5A5A5) -> BUSY high for exactly 4096 cycles, 4096 writes with addresses 0..4095, no GNT. Reads of addr 0 and 4095 then return 32'hA5A5A5A5.
- R0 writes 32'hDEADBEEF to addr 12'h123; R0 reads 12'h123 -> GNT0 one cycle after each REQ becomes eligible. RVALID0 exactly 1 cycle after the read's GNT0, with RDATA=32'hDEADBEEF.
- R0 and R1 request reads continuously (addr 1, 2) -> grants alternate R0,R1,R0,R1, one per cycle. RVALIDs alternate, never overlap.
- Single requester holding REQ0 high with reads -> GNT0 every other cycle, never two consecutive cycles.
- R1 writes 32'h0000_0042 to addr 7, and R0 reads addr 7 in the next granted slot -> RDATA=32'h42.
- RSTN asserted on the cycle between a read GNT and its RVALID -> no RVALID after reset; MEM_CEN=1. With the macro on, BUSY returns to 1 and the sweep restarts at address 0.
